// File: rtl/mem_resp_stage.sv
// mem_resp_stage: one-entry memory-response pipeline register.
// Waits for an in-order data-SRAM response (data_ok/rdata) for load entries.
// Extracts and sign/zero-extends byte/half/word/double loads.
// Buffers an early response while writeback stalls.
// Discards responses owed to loads killed by a flush.
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   flush              kills the stage entry
//   in_*               upstream entry fields and handshake
//   data_ok, rdata     in-order response strobe and data
//   out_*              entry to writeback and handshake
//   fwd_*              forwarding / interlock bus to decode
//   cancel_full        cancel counter saturated; upstream is stalled
module mem_resp_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PASS_W     = 128,
  parameter int unsigned MAX_CANCEL = 3
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_allowin,
  input  logic [PASS_W-1:0]             in_payload,
  input  logic [DATA_W-1:0]             in_result,
  input  logic                          in_gr_we,
  input  logic [4:0]                    in_dest,
  input  logic                          in_is_load,
  input  logic                          in_req_sent,
  input  logic [1:0]                    in_ld_size,
  input  logic                          in_ld_unsigned,
  input  logic [$clog2(DATA_W/8)-1:0]   in_addr_lo,
  input  logic                          data_ok,
  input  logic [DATA_W-1:0]             rdata,
  output logic                          out_valid,
  input  logic                          out_allowin,
  output logic [PASS_W-1:0]             out_payload,
  output logic [DATA_W-1:0]             out_result,
  output logic                          out_gr_we,
  output logic [4:0]                    out_dest,
  output logic [4:0]                    fwd_dest,
  output logic [DATA_W-1:0]             fwd_result,
  output logic                          fwd_pending,
  output logic                          cancel_full
);

  localparam int unsigned AW = $clog2(DATA_W / 8);
  localparam int unsigned CW = $clog2(MAX_CANCEL + 1);
  localparam int unsigned LW = $clog2(DATA_W);

  // Stage entry
  logic              valid;
  logic [PASS_W-1:0] payload_q;
  logic [DATA_W-1:0] result_q;
  logic              gr_we_q;
  logic [4:0]        dest_q;
  logic              is_load_q;
  logic              req_sent_q;
  logic [1:0]        ld_size_q;
  logic              ld_uns_q;
  logic [AW-1:0]     addr_lo_q;

  // Early-response buffer and count of responses owed to flushed loads
  logic              hold_vld;
  logic [DATA_W-1:0] hold_q;
  logic [CW-1:0]     cancel_cnt;
  logic [CW-1:0]     cancel_nxt;

  logic waiting;
  logic cnt_zero;
  logic own_rsp;
  logic ready_go;
  logic leave;
  logic load_en;
  logic capture;
  logic cnt_inc;
  logic cnt_dec;

  logic [DATA_W-1:0] src;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic [DATA_W-1:0] extracted;
  logic [1:0]        eff_size;
  logic [AW-1:0]     lo_mask;
  logic [AW-1:0]     lane;
  logic [6:0]        nbits;
  logic              sign_bit;

  // Handshake and response routing
  always_comb begin
    cnt_zero    = (cancel_cnt == '0);
    waiting     = valid & is_load_q & req_sent_q & ~hold_vld;
    own_rsp     = data_ok & cnt_zero;
    ready_go    = ~waiting | own_rsp;
    cancel_full = (cancel_cnt == CW'(MAX_CANCEL));
    in_allowin  = (~valid | (ready_go & out_allowin)) & ~cancel_full;
    out_valid   = valid & ready_go & ~flush;
    leave       = valid & ready_go & out_allowin;
    load_en     = in_valid & in_allowin & ~flush;
    // Response for the entry arrived but writeback is not taking it yet
    capture     = own_rsp & waiting & ~out_allowin & ~flush;
    // A killed waiting load still owes its response unless it came this cycle
    cnt_inc     = flush & waiting & ~own_rsp;
    cnt_dec     = data_ok & ~cnt_zero;
    fwd_pending = valid & waiting & ~own_rsp;
  end

  // Next cancel count, saturating at MAX_CANCEL
  always_comb begin
    cancel_nxt = cancel_cnt;
    if (cnt_inc && !cnt_dec && !cancel_full) begin
      cancel_nxt = cancel_cnt + CW'(1);
    end else if (cnt_dec && !cnt_inc) begin
      cancel_nxt = cancel_cnt - CW'(1);
    end
  end

  // Load data extraction: align the lane to bit 0, then mask and extend
  always_comb begin
    src       = hold_vld ? hold_q : rdata;
    // Without a 64-bit datapath a double request degrades to a word
    eff_size  = (DATA_W == 32 && ld_size_q == 2'd3) ? 2'd2 : ld_size_q;
    lo_mask   = AW'((4'd1 << eff_size) - 4'd1);
    lane      = addr_lo_q & ~lo_mask;
    shifted   = src >> {lane, 3'b000};
    nbits     = 7'd8 << eff_size;
    keep      = {DATA_W{1'b1}} >> (7'(DATA_W) - nbits);
    sign_bit  = shifted[LW'(nbits - 7'd1)];
    extracted = (shifted & keep) | ((!ld_uns_q && sign_bit) ? ~keep : '0);
  end

  // State and entry registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid      <= 1'b0;
      payload_q  <= '0;
      result_q   <= '0;
      gr_we_q    <= 1'b0;
      dest_q     <= '0;
      is_load_q  <= 1'b0;
      req_sent_q <= 1'b0;
      ld_size_q  <= '0;
      ld_uns_q   <= 1'b0;
      addr_lo_q  <= '0;
      hold_vld   <= 1'b0;
      hold_q     <= '0;
      cancel_cnt <= '0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (in_allowin) begin
        valid <= in_valid;
      end
      if (load_en) begin
        payload_q  <= in_payload;
        result_q   <= in_result;
        gr_we_q    <= in_gr_we;
        dest_q     <= in_dest;
        is_load_q  <= in_is_load;
        req_sent_q <= in_req_sent;
        ld_size_q  <= in_ld_size;
        ld_uns_q   <= in_ld_unsigned;
        addr_lo_q  <= in_addr_lo;
      end
      if (flush || leave) begin
        hold_vld <= 1'b0;
      end else if (capture) begin
        hold_vld <= 1'b1;
        hold_q   <= rdata;
      end
      cancel_cnt <= cancel_nxt;
    end
  end

  // Output and forwarding views of the entry
  always_comb begin
    out_payload = payload_q;
    out_result  = is_load_q ? extracted : result_q;
    out_gr_we   = gr_we_q;
    out_dest    = dest_q;
    fwd_result  = out_result;
    fwd_dest    = (valid && gr_we_q) ? dest_q : 5'd0;
  end

endmodule

// File: tb/tb_mem_resp_stage.sv
// Scoreboard bench for mem_resp_stage: a 32-bit instance (u32) and a
// 64-bit instance (u64); monitors pop expected results on each transfer.
module tb_mem_resp_stage;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  dest;
    logic [63:0] tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  // 32-bit instance signals
  logic         flush, in_valid, in_allowin, in_gr_we, in_is_load, in_req_sent;
  logic         in_ld_unsigned, data_ok, out_valid, out_allowin, out_gr_we;
  logic         fwd_pending, cancel_full;
  logic [127:0] in_payload, out_payload;
  logic [31:0]  in_result, rdata, out_result, fwd_result;
  logic [4:0]   in_dest, out_dest, fwd_dest;
  logic [1:0]   in_ld_size, in_addr_lo;

  // 64-bit instance signals
  logic         d_flush, d_in_valid, d_in_allowin, d_in_gr_we, d_in_is_load, d_in_req_sent;
  logic         d_in_ld_unsigned, d_data_ok, d_out_valid, d_out_allowin, d_out_gr_we;
  logic         d_fwd_pending, d_cancel_full;
  logic [127:0] d_in_payload, d_out_payload;
  logic [63:0]  d_in_result, d_rdata, d_out_result, d_fwd_result;
  logic [4:0]   d_in_dest, d_out_dest, d_fwd_dest;
  logic [1:0]   d_in_ld_size;
  logic [2:0]   d_in_addr_lo;

  mem_resp_stage #(.DATA_W(32), .PASS_W(128), .MAX_CANCEL(3)) u32 (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_allowin(in_allowin),
    .in_payload(in_payload), .in_result(in_result), .in_gr_we(in_gr_we), .in_dest(in_dest),
    .in_is_load(in_is_load), .in_req_sent(in_req_sent), .in_ld_size(in_ld_size),
    .in_ld_unsigned(in_ld_unsigned), .in_addr_lo(in_addr_lo), .data_ok(data_ok), .rdata(rdata),
    .out_valid(out_valid), .out_allowin(out_allowin), .out_payload(out_payload),
    .out_result(out_result), .out_gr_we(out_gr_we), .out_dest(out_dest), .fwd_dest(fwd_dest),
    .fwd_result(fwd_result), .fwd_pending(fwd_pending), .cancel_full(cancel_full));

  mem_resp_stage #(.DATA_W(64), .PASS_W(128), .MAX_CANCEL(3)) u64 (
    .clk(clk), .rstn(rstn), .flush(d_flush), .in_valid(d_in_valid), .in_allowin(d_in_allowin),
    .in_payload(d_in_payload), .in_result(d_in_result), .in_gr_we(d_in_gr_we), .in_dest(d_in_dest),
    .in_is_load(d_in_is_load), .in_req_sent(d_in_req_sent), .in_ld_size(d_in_ld_size),
    .in_ld_unsigned(d_in_ld_unsigned), .in_addr_lo(d_in_addr_lo), .data_ok(d_data_ok), .rdata(d_rdata),
    .out_valid(d_out_valid), .out_allowin(d_out_allowin), .out_payload(d_out_payload),
    .out_result(d_out_result), .out_gr_we(d_out_gr_we), .out_dest(d_out_dest), .fwd_dest(d_fwd_dest),
    .fwd_result(d_fwd_result), .fwd_pending(d_fwd_pending), .cancel_full(d_cancel_full));

  int   total = 0;
  int   bad   = 0;
  int   tag   = 1;
  exp_t q32[$];
  exp_t q64[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitors: compare each transfer to writeback against the scoreboard
  always @(negedge clk) begin
    if (rstn && out_valid && out_allowin) begin
      if (q32.size() == 0) begin
        chk("u32_unexpected_out", 64'(out_result), 64'hx);
      end else begin
        exp_t e;
        e = q32.pop_front();
        chk("u32_result", 64'(out_result), e.res);
        chk("u32_fwd_result", 64'(fwd_result), e.res);
        chk("u32_dest", 64'(out_dest), 64'(e.dest));
        chk("u32_payload", 64'(out_payload), e.tag);
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && d_out_valid && d_out_allowin) begin
      if (q64.size() == 0) begin
        chk("u64_unexpected_out", d_out_result, 64'hx);
      end else begin
        exp_t e;
        e = q64.pop_front();
        chk("u64_result", d_out_result, e.res);
        chk("u64_payload", 64'(d_out_payload), e.tag);
      end
    end
  end

  // Present an entry to u32 and wait (bounded) until it is accepted
  task automatic send32(input bit ld, input logic [1:0] sz, input bit uns, input logic [1:0] a,
                        input logic [31:0] res, input logic [4:0] dst, input bit we,
                        input bit push, input logic [31:0] exp_res);
    bit acc = 1'b0;
    in_valid = 1'b1; in_is_load = ld; in_ld_size = sz; in_ld_unsigned = uns; in_addr_lo = a;
    in_result = res; in_dest = dst; in_gr_we = we; in_req_sent = ld;
    in_payload = 128'(tag);
    if (push) q32.push_back('{res: 64'(exp_res), dest: dst, tag: 64'(tag)});
    tag++;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_allowin && !flush;
      cyc();
    end
    in_valid = 1'b0;
    if (!acc) chk("u32_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send64(input logic [1:0] sz, input bit uns, input logic [2:0] a,
                        input logic [63:0] exp_res);
    bit acc = 1'b0;
    d_in_valid = 1'b1; d_in_is_load = 1'b1; d_in_ld_size = sz; d_in_ld_unsigned = uns;
    d_in_addr_lo = a; d_in_dest = 5'd9; d_in_gr_we = 1'b1; d_in_req_sent = 1'b1;
    d_in_payload = 128'(tag);
    q64.push_back('{res: exp_res, dest: 5'd9, tag: 64'(tag)});
    tag++;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = d_in_allowin;
      cyc();
    end
    d_in_valid = 1'b0;
    if (!acc) chk("u64_accept_timeout", 64'd0, 64'd1);
  endtask

  // One u64 load with its response in the entry's first cycle
  task automatic load64(input logic [1:0] sz, input bit uns, input logic [2:0] a,
                        input logic [63:0] exp_res);
    send64(sz, uns, a, exp_res);
    d_data_ok = 1'b1; d_rdata = 64'h0123_4567_89AB_CDEF;
    cyc();
    d_data_ok = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_payload = '0; in_result = '0; in_gr_we = 1'b0;
    in_dest = '0; in_is_load = 1'b0; in_req_sent = 1'b0; in_ld_size = '0; in_ld_unsigned = 1'b0;
    in_addr_lo = '0; data_ok = 1'b0; rdata = '0; out_allowin = 1'b1;
    d_flush = 1'b0; d_in_valid = 1'b0; d_in_payload = '0; d_in_result = '0; d_in_gr_we = 1'b0;
    d_in_dest = '0; d_in_is_load = 1'b0; d_in_req_sent = 1'b0; d_in_ld_size = '0;
    d_in_ld_unsigned = 1'b0; d_in_addr_lo = '0; d_data_ok = 1'b0; d_rdata = '0; d_out_allowin = 1'b1;

    repeat (3) cyc();
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fwd_dest", 64'(fwd_dest), 64'd0);
    chk("rst_fwd_pending", 64'(fwd_pending), 64'd0);
    chk("rst_cancel_full", 64'(cancel_full), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_in_allowin", 64'(in_allowin), 64'd1);
    cyc();
    rstn = 1'b1;
    cyc();

    // Byte load, signed then unsigned, response in first cycle
    send32(1, 2'd0, 0, 2'd2, 32'h0, 5'd5, 1, 1, 32'hFFFF_FFFF);
    data_ok = 1'b1; rdata = 32'h80FF_7F01;
    cyc();
    data_ok = 1'b0;
    send32(1, 2'd0, 1, 2'd2, 32'h0, 5'd6, 1, 1, 32'h0000_00FF);
    data_ok = 1'b1; rdata = 32'h80FF_7F01;
    cyc();
    data_ok = 1'b0;

    // Writeback stall: early response is held
    out_allowin = 1'b0;
    send32(1, 2'd1, 0, 2'd2, 32'h0, 5'd7, 1, 1, 32'hFFFF_8001);
    data_ok = 1'b1; rdata = 32'h8001_1234;
    cyc();
    data_ok = 1'b0; rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_out_result", 64'(out_result), 64'h0000_0000_FFFF_8001);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_fwd_pending", 64'(fwd_pending), 64'd0);
      chk("stall_in_allowin", 64'(in_allowin), 64'd0);
      cyc();
    end
    out_allowin = 1'b1;
    cyc();

    // Late word response: four cycles of interlock
    send32(1, 2'd2, 0, 2'd0, 32'h0, 5'd8, 1, 1, 32'hCAFE_F00D);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("late_fwd_pending", 64'(fwd_pending), 64'd1);
      chk("late_out_valid", 64'(out_valid), 64'd0);
      chk("late_fwd_dest", 64'(fwd_dest), 64'd8);
      cyc();
    end
    data_ok = 1'b1; rdata = 32'hCAFE_F00D;
    cyc();
    data_ok = 1'b0;

    // Flush a waiting load; the next load's first response is stale
    send32(1, 2'd2, 0, 2'd0, 32'h0, 5'd10, 1, 0, 32'h0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    cyc();
    flush = 1'b0;
    send32(1, 2'd2, 0, 2'd0, 32'h0, 5'd11, 1, 1, 32'h1234_5678);
    data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("stale_out_valid", 64'(out_valid), 64'd0);
    chk("stale_fwd_pending", 64'(fwd_pending), 64'd1);
    cyc();
    rdata = 32'h1234_5678;
    cyc();
    data_ok = 1'b0;

    // Cancel counter saturation
    for (int k = 0; k < 3; k++) begin
      send32(1, 2'd2, 0, 2'd0, 32'h0, 5'd12, 1, 0, 32'h0);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
    end
    @(negedge clk);
    chk("sat_cancel_full", 64'(cancel_full), 64'd1);
    chk("sat_in_allowin", 64'(in_allowin), 64'd0);
    cyc();
    data_ok = 1'b1; rdata = 32'h5555_5555;
    cyc();
    data_ok = 1'b0;
    @(negedge clk);
    chk("unsat_cancel_full", 64'(cancel_full), 64'd0);
    chk("unsat_in_allowin", 64'(in_allowin), 64'd1);
    cyc();
    data_ok = 1'b1;
    repeat (2) cyc();
    data_ok = 1'b0;

    // Non-load passes its result; no write enable means no forwarding dest
    send32(0, 2'd0, 0, 2'd0, 32'h1111_2222, 5'd3, 0, 1, 32'h1111_2222);
    @(negedge clk);
    chk("nonload_fwd_dest", 64'(fwd_dest), 64'd0);
    cyc();
    // Word load after the drain: counter back at zero, response delivered
    send32(1, 2'd2, 0, 2'd0, 32'h0, 5'd13, 1, 1, 32'h7654_3210);
    data_ok = 1'b1; rdata = 32'h7654_3210;
    cyc();
    data_ok = 1'b0;

    // 64-bit datapath
    load64(2'd3, 0, 3'd0, 64'h0123_4567_89AB_CDEF);
    load64(2'd2, 0, 3'd4, 64'h0000_0000_0123_4567);
    load64(2'd2, 0, 3'd0, 64'hFFFF_FFFF_89AB_CDEF);
    load64(2'd1, 0, 3'd2, 64'hFFFF_FFFF_FFFF_89AB);
    load64(2'd0, 1, 3'd7, 64'h0000_0000_0000_0001);

    for (int i = 0; i < 20 && (q32.size() != 0 || q64.size() != 0); i++) cyc();
    chk("drain_q32", 64'(q32.size()), 64'd0);
    chk("drain_q64", 64'(q64.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_resp_stage.md
Name: mem_resp_stage

Overview:
- Parametrised successor to the single-cycle memory stage.
- A one-entry pipeline register that waits for an in-order data-SRAM response (data_ok/rdata) instead of assuming the data arrives with the request.
- Extracts and sign- or zero-extends byte, half, word and (when DATA_W=64) double loads. Buffers an early response while the writeback stage stalls.
- On an exception flush, drops responses that belong to cancelled loads and provides a forwarding/interlock bus to decode.

Parameters:
DATA_W, 32, datapath and rdata width; legal values 32 or 64.
PASS_W, 128, width of opaque sideband payload (pc, dest, csr fields) carried through unchanged.
MAX_CANCEL, 3, maximum number of outstanding responses owed to flushed loads; sizes the cancel counter.

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
flush  in  1  exception/ertn flush; kills the stage entry
in_valid  in  1  upstream entry valid
in_allowin  out  1  stage can accept an entry this cycle
in_payload  in  PASS_W  sideband payload
in_result  in  DATA_W  non-load result
in_gr_we  in  1  register write enable
in_dest  in  5  destination register
in_is_load  in  1  entry is a load
in_req_sent  in  1  a data request was accepted for this entry
in_ld_size  in  2  0 byte, 1 half, 2 word, 3 double
in_ld_unsigned  in  1  zero-extend
in_addr_lo  in  $clog2(DATA_W/8)  low address bits
data_ok  in  1  response strobe, in request order
rdata  in  DATA_W  response data
out_valid  out  1  entry valid to writeback
out_allowin  in  1  writeback can accept
out_payload  out  PASS_W  registered payload
out_result  out  DATA_W  final result
out_gr_we  out  1  registered write enable
out_dest  out  5  registered destination register
fwd_dest  out  5  dest when valid and gr_we, else 0
fwd_result  out  DATA_W  final result for forwarding
fwd_pending  out  1  valid load still waiting on data; decode must stall
cancel_full  out  1  cancel counter at MAX_CANCEL

Behaviour:
- Reset (rstn=0 at clk edge) clears the following to 0: valid, hold_vld, cancel_cnt and all registered fields. Consequently out_valid=0, fwd_dest=0, fwd_pending=0, cancel_full=0, out_result=0.
- Handshake:
  - waiting = valid & is_load & req_sent & !hold_vld.
  - ready_go = !waiting | (data_ok & cancel_cnt==0).
  - in_allowin = !valid | (ready_go & out_allowin); it is additionally forced 0 when cancel_full.
  - out_valid = valid & ready_go & !flush.
- Load: when in_valid & in_allowin & !flush, all in_* fields are latched and valid is set to 1. Otherwise, if in_allowin, valid is cleared to 0.
- Response routing, per data_ok cycle:
  - cancel_cnt>0: the response is discarded and cancel_cnt decrements.
  - cancel_cnt==0 and waiting: the response belongs to the entry. If the entry does not leave this cycle, rdata is captured into hold and hold_vld is set to 1.
  - data_ok with no consumer and cancel_cnt==0 is a protocol error; the response is ignored.
- hold_vld clears whenever the entry leaves or is flushed.
- Data source = hold_vld ? hold : rdata. Extraction uses lane = in_addr_lo scaled by the size:
  - byte: bits [8*a +: 8]
  - half: [16*a[..1] +: 16]
  - word: [32*a[..2] +: 32]
  - double: the whole 64-bit word
- Sign-extend to DATA_W unless ld_unsigned. For DATA_W=32, size 3 is treated as word.
- out_result = fwd_result = is_load ? extracted : result.
- fwd_pending = valid & waiting & !(data_ok & cancel_cnt==0).
- Flush:
  - valid and hold_vld are cleared to 0 at the next edge.
  - If the killed entry was waiting and its response did not arrive this cycle, cancel_cnt increments.
  - A simultaneous data_ok with cancel_cnt>0 decrements the counter, giving a net change of 0.
  - A new entry is not loaded in a flush cycle.
- cancel_cnt never exceeds MAX_CANCEL. cancel_full stalls upstream so that no new requests accumulate.
- Latency: a non-load, or a load whose data_ok arrives in its first cycle, presents out_valid 1 cycle after it is latched. A held entry issues 1 beat per out_allowin.

Test Plan:
- Byte load: DATA_W=32, rdata=0x80FF_7F01, addr_lo=2, size 0, signed; data_ok in the same cycle -> out_result=0xFFFF_FFFF. The same stimulus with unsigned -> 0x0000_00FF.
- Stall: out_allowin=0 for 3 cycles. Half load addr_lo=2, rdata=0x8001_1234, data_ok in cycle 1 -> hold keeps data; out_result=0xFFFF_8001 stays constant; fwd_pending=0; in_allowin=0 until out_allowin=1.
- Late response: word load, data_ok 4 cycles late -> fwd_pending=1 and out_valid=0 for 4 cycles, then out_valid=1 with out_result=rdata.
- Flush with outstanding load: flush while waiting -> cancel_cnt=1. The next load's first data_ok (0xDEAD_BEEF) is discarded; the second data_ok (0x1234_5678) is delivered as out_result=0x1234_5678.
- Cancel saturation: MAX_CANCEL=3, three flushed waiting loads -> cancel_full=1 and in_allowin=0. After one data_ok -> cancel_full=0.
- Doubleword: DATA_W=64, size 3, rdata=0x0123_4567_89AB_CDEF -> out_result equals rdata. Word addr_lo=4, signed -> 0x0000_0000_0123_4567.
